// File: rtl/poly_tone_generator.sv
// poly_tone_generator
//   Multi-channel square-wave tone generator with a first-order delta-sigma
//   mixer producing a single-bit audio stream.
//
// Parameters
//   NUM_CH   : number of tone channels (1..16)
//   PERIOD_W : width of each channel's half-period, in clocks
//   VOL_W    : width of each channel's volume code
//
// Ports
//   clk                : single clock, rising edge
//   rst_n              : asynchronous active-low reset
//   output_enable      : global run/mute
//   channel_enable     : per-channel run bit
//   tone_switch_period : per-channel half-period, channel k at [k*PERIOD_W +: PERIOD_W]
//   volume             : per-channel volume code, channel k at [k*VOL_W +: VOL_W]
//   square_wave_out    : registered delta-sigma mixed bitstream
//   tone_state         : per-channel square-wave level
//   active             : registered "any channel running" flag
module poly_tone_generator #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned VOL_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         output_enable,
    input  logic [NUM_CH-1:0]            channel_enable,
    input  logic [NUM_CH*PERIOD_W-1:0]   tone_switch_period,
    input  logic [NUM_CH*VOL_W-1:0]      volume,
    output logic                         square_wave_out,
    output logic [NUM_CH-1:0]            tone_state,
    output logic                         active
);

    localparam int unsigned FULL  = NUM_CH * ((1 << VOL_W) - 1);
    // acc < FULL and sum <= FULL, so acc + sum < 2*FULL
    localparam int unsigned ACC_W = $clog2(2 * FULL) + 1;
    localparam logic [ACC_W-1:0] FULL_V = ACC_W'(FULL);

    logic                 run_en_q;
    logic [NUM_CH-1:0]    running;
    logic [NUM_CH-1:0]    tone_q, tone_d;
    logic [PERIOD_W-1:0]  cnt_q [NUM_CH];
    logic [PERIOD_W-1:0]  cnt_d [NUM_CH];
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     sum;
    logic [ACC_W-1:0]     acc_next;
    logic                 sq_q, sq_d;
    logic                 active_q;

    // Channel counters. run_en_q holds everything idle for the first edge
    // after reset release so no state can change on that edge.
    always_comb begin : channel_next
        logic [PERIOD_W-1:0] per;
        per = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            per        = tone_switch_period[k*PERIOD_W +: PERIOD_W];
            running[k] = run_en_q & output_enable & channel_enable[k] & (per != '0);
            cnt_d[k]   = '0;
            tone_d[k]  = 1'b0;
            if (running[k]) begin
                // >= rather than == so a shortened period toggles at once
                // instead of wrapping through 2^PERIOD_W
                if (cnt_q[k] >= per - PERIOD_W'(1)) begin
                    cnt_d[k]  = '0;
                    tone_d[k] = ~tone_q[k];
                end else begin
                    cnt_d[k]  = cnt_q[k] + PERIOD_W'(1);
                    tone_d[k] = tone_q[k];
                end
            end
        end
    end

    // Mixer: sum of volumes of high channels drives a first-order
    // delta-sigma accumulator with modulus FULL.
    always_comb begin : mixer_next
        sum = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (tone_q[k]) begin
                sum = sum + ACC_W'(volume[k*VOL_W +: VOL_W]);
            end
        end
        acc_next = acc_q + sum;
        acc_d    = '0;
        sq_d     = 1'b0;
        if (output_enable) begin
            if (acc_next >= FULL_V) begin
                sq_d  = 1'b1;
                acc_d = acc_next - FULL_V;
            end else begin
                acc_d = acc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en_q <= 1'b0;
            tone_q   <= '0;
            acc_q    <= '0;
            sq_q     <= 1'b0;
            active_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            run_en_q <= 1'b1;
            tone_q   <= tone_d;
            acc_q    <= acc_d;
            sq_q     <= sq_d;
            active_q <= |running;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign square_wave_out = sq_q;
    assign tone_state      = tone_q;
    assign active          = active_q;

endmodule

// File: tb/tb_poly_tone_generator.sv
module tb_poly_tone_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        oe;
    logic [3:0]  en;
    logic [95:0] per;
    logic [11:0] vol;
    logic        sq;
    logic [3:0]  tone;
    logic        act;

    logic        oe8;
    logic [0:0]  en8;
    logic [7:0]  per8;
    logic [0:0]  vol8;
    logic        sq8;
    logic [0:0]  tone8;
    logic        act8;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    poly_tone_generator dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .output_enable      (oe),
        .channel_enable     (en),
        .tone_switch_period (per),
        .volume             (vol),
        .square_wave_out    (sq),
        .tone_state         (tone),
        .active             (act)
    );

    poly_tone_generator #(
        .NUM_CH   (1),
        .PERIOD_W (8),
        .VOL_W    (1)
    ) dut8 (
        .clk                (clk),
        .rst_n              (rst_n),
        .output_enable      (oe8),
        .channel_enable     (en8),
        .tone_switch_period (per8),
        .volume             (vol8),
        .square_wave_out    (sq8),
        .tone_state         (tone8),
        .active             (act8)
    );

    typedef struct {
        string       name;
        logic        oe;
        logic [3:0]  en;
        logic [95:0] per;
        logic [11:0] vol;
        int          cycles;
        logic [3:0]  exp_tone;
        logic        exp_act;
        int          exp_ones;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [95:0] p4(input int a, input int b, input int c, input int d);
        logic [23:0] pa, pb, pc, pd;
        pa = 24'(a); pb = 24'(b); pc = 24'(c); pd = 24'(d);
        return {pd, pc, pb, pa};
    endfunction

    function automatic logic [11:0] v4(input int a, input int b, input int c, input int d);
        logic [2:0] va, vb, vc, vd;
        va = 3'(a); vb = 3'(b); vc = 3'(c); vd = 3'(d);
        return {vd, vc, vb, va};
    endfunction

    task automatic add(input string nm, input logic o, input logic [3:0] e,
                       input logic [95:0] p, input logic [11:0] v, input int n,
                       input logic [3:0] et, input logic ea, input int eo);
        vec_t r;
        r.name = nm; r.oe = o; r.en = e; r.per = p; r.vol = v; r.cycles = n;
        r.exp_tone = et; r.exp_act = ea; r.exp_ones = eo;
        vecs.push_back(r);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mute();
        oe = 1'b0;
        tick();
        tick();
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (sq === 1'b1) ones++;
        end
    endtask

    initial begin
        int ones;

        rst_n = 1'b0;
        oe = 1'b0; en = '0; per = '0; vol = '0;
        oe8 = 1'b0; en8 = '0; per8 = '0; vol8 = '0;
        #1;
        check("reset_sq", 32'(sq), 0);
        check("reset_tone", 32'(tone), 0);
        check("reset_active", 32'(act), 0);
        #21 rst_n = 1'b1;
        tick();
        tick();

        //   name       oe  en       periods          volumes        N   tone     act ones
        add("one_ch",   1, 4'b0001, p4(4,4,4,4),     v4(7,7,7,7),   8,  4'b0000, 1,  1);
        add("four_ch",  1, 4'b1111, p4(4,4,4,4),     v4(7,7,7,7),   8,  4'b0000, 1,  4);
        add("per1",     1, 4'b1111, p4(1,1,1,1),     v4(7,7,7,7),   8,  4'b0000, 1,  4);
        add("per0",     1, 4'b0001, p4(0,4,4,4),     v4(7,7,7,7),   5,  4'b0000, 0,  0);
        add("ch_off",   1, 4'b0000, p4(4,4,4,4),     v4(7,7,7,7),   6,  4'b0000, 0,  0);
        add("mixed",    1, 4'b0011, p4(2,3,0,0),     v4(3,5,0,0),   11, 4'b0011, 1,  1);
        add("vol0",     1, 4'b0001, p4(2,0,0,0),     v4(0,0,0,0),   6,  4'b0001, 1,  0);
        add("oe_off",   0, 4'b1111, p4(4,4,4,4),     v4(7,7,7,7),   6,  4'b0000, 0,  0);
        add("per8",     1, 4'b0001, p4(8,0,0,0),     v4(7,0,0,0),   8,  4'b0001, 1,  0);

        foreach (vecs[i]) begin
            mute();
            en = vecs[i].en; per = vecs[i].per; vol = vecs[i].vol; oe = vecs[i].oe;
            count_ones(vecs[i].cycles, ones);
            check({vecs[i].name, "_tone"}, 32'(tone), 32'(vecs[i].exp_tone));
            check({vecs[i].name, "_active"}, 32'(act), 32'(vecs[i].exp_act));
            check({vecs[i].name, "_ones"}, 32'(ones), 32'(vecs[i].exp_ones));
        end

        // Window density: all channels in phase, then ch0 alone
        mute();
        en = 4'b1111; per = p4(1250,1250,1250,1250); vol = v4(7,7,7,7); oe = 1'b1;
        repeat (1250) tick();
        check("win_tone_high", 32'(tone), 32'hF);
        count_ones(2500, ones);
        check("win_all_ones", 32'(ones), 1250);
        mute();
        en = 4'b0001; oe = 1'b1;
        repeat (1250) tick();
        count_ones(2500, ones);
        check("win_ch0_ones", 32'(ones), 312);

        // Period shortened below current count
        mute();
        en = 4'b0001; per = p4(100,0,0,0); vol = v4(0,0,0,0); oe = 1'b1;
        repeat (10) tick();
        per = p4(5,0,0,0);
        tick();
        check("pchg_first", 32'(tone), 1);
        repeat (4) tick();
        check("pchg_hold", 32'(tone), 1);
        tick();
        check("pchg_second", 32'(tone), 0);

        // Mute while all channels high, then restart
        mute();
        en = 4'b1111; per = p4(4,4,4,4); vol = v4(7,7,7,7); oe = 1'b1;
        repeat (5) tick();
        check("mute_pre_tone", 32'(tone), 32'hF);
        check("mute_pre_sq", 32'(sq), 1);
        oe = 1'b0;
        tick();
        check("mute_sq", 32'(sq), 0);
        check("mute_tone", 32'(tone), 0);
        check("mute_active", 32'(act), 0);
        oe = 1'b1;
        repeat (3) tick();
        check("restart_early", 32'(tone), 0);
        tick();
        check("restart_edge", 32'(tone), 32'hF);

        // Async reset between edges, then release latency
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_sq", 32'(sq), 0);
        check("async_tone", 32'(tone), 0);
        check("async_active", 32'(act), 0);
        per = p4(1,1,1,1);
        #3 rst_n = 1'b1;
        tick();
        check("rel_edge1_tone", 32'(tone), 0);
        check("rel_edge1_active", 32'(act), 0);
        tick();
        check("rel_edge2_tone", 32'(tone), 32'hF);
        check("rel_edge2_active", 32'(act), 1);
        oe = 1'b0;

        // Narrow instance: 1 channel, 1-bit volume, 8-bit period
        oe8 = 1'b1; en8 = 1'b1; per8 = 8'd255; vol8 = 1'b1;
        repeat (254) tick();
        check("n8_before", 32'(tone8), 0);
        tick();
        check("n8_toggle", 32'(tone8), 1);
        check("n8_active", 32'(act8), 1);
        ones = 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (sq8 === 1'b1) ones++;
        end
        check("n8_ones", 32'(ones), 255);
        check("n8_toggle_low", 32'(tone8), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
